cond_logic: RTL

- Conditional-execution stage directly downstream of the instruction decoder in the single-cycle ARM-subset controller.
- Holds the architectural NZCV flag register and evaluates the instruction Cond field against the stored flags.
- Gates the decoder's raw PCS/RegW/MemW into the committed PCSrc/RegWrite/MemWrite strobes for the datapath.
- Commits new ALU flags only when the instruction executes and the decoder requests it (FlagW).

---
 rtl/cond_logic.sv | 126 ++++++++++++
 1 files changed

// File: rtl/cond_logic.sv
// -----------------------------------------------------------------------------
// cond_logic
//
// Conditional-execution stage of the single-cycle ARM-subset controller. It
// sits directly downstream of the instruction decoder and does three things:
//   1. Holds the architectural flag register {N,Z,C,V}.
//   2. Evaluates the instruction's Cond field against the stored flags to
//      produce CondEx with zero latency.
//   3. Gates the decoder's raw PCS/RegW/MemW requests into the committed
//      PCSrc/RegWrite/MemWrite strobes. It commits new ALU flags only for an
//      executing instruction that asks for them through FlagW.
//
// Ports
//   clk       in   1       system clock, rising-edge active
//   reset     in   1       synchronous, active-high reset
//   en        in   1       instruction-commit enable (0 = stall)
//   Cond      in   4       instruction bits [31:28]
//   ALUFlags  in   FLAG_W  {N,Z,C,V} produced by the ALU this cycle
//   FlagW     in   2       [1] = write N,Z ; [0] = write C,V
//   PCS       in   1       decoder PC-write request
//   RegW      in   1       decoder register-write request
//   MemW      in   1       decoder memory-write request
//   PCSrc     out  1       committed PC select
//   RegWrite  out  1       committed register-file write enable
//   MemWrite  out  1       committed data-memory write enable
//   CondEx    out  1       condition passed for the current instruction
//   Flags     out  FLAG_W  registered {N,Z,C,V}, for debug/trace
// -----------------------------------------------------------------------------
module cond_logic #(
  parameter int FLAG_W = 4  // fixed {N,Z,C,V}; named only for readability
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [3:0]        Cond,
  input  logic [FLAG_W-1:0] ALUFlags,
  input  logic [1:0]        FlagW,
  input  logic              PCS,
  input  logic              RegW,
  input  logic              MemW,
  output logic              PCSrc,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic              CondEx,
  output logic [FLAG_W-1:0] Flags
);

  // ARM condition-code encodings.
  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  logic [FLAG_W-1:0] flags_q;
  logic              flag_n, flag_z, flag_c, flag_v;
  logic              cond_ex;
  logic              commit;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  // Condition evaluation always looks at the registered (pre-edge) flags.
  // The current instruction's own ALU flags are never bypassed in here.
  always_comb begin
    // NOTE: default assignment first so every path drives cond_ex and no
    // latch is inferred, even if a case arm is later removed.
    cond_ex = 1'b0;
    unique case (cond_e'(Cond))
      COND_EQ: cond_ex = flag_z;
      COND_NE: cond_ex = ~flag_z;
      COND_CS: cond_ex = flag_c;
      COND_CC: cond_ex = ~flag_c;
      COND_MI: cond_ex = flag_n;
      COND_PL: cond_ex = ~flag_n;
      COND_VS: cond_ex = flag_v;
      COND_VC: cond_ex = ~flag_v;
      COND_HI: cond_ex = flag_c & ~flag_z;
      COND_LS: cond_ex = ~flag_c | flag_z;
      COND_GE: cond_ex = (flag_n == flag_v);
      COND_LT: cond_ex = (flag_n != flag_v);
      COND_GT: cond_ex = ~flag_z & (flag_n == flag_v);
      COND_LE: cond_ex = flag_z | (flag_n != flag_v);
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = 1'b0;  // unsupported encoding: squash the instruction
      default: cond_ex = 1'b0;
    endcase
  end

  // An instruction commits only when its condition passes, the pipeline is
  // not stalled and reset is low. Forcing the strobes low during reset keeps
  // the datapath from writing while the flag register is still undefined.
  assign commit   = cond_ex & en & ~reset;

  assign PCSrc    = PCS  & commit;
  assign RegWrite = RegW & commit;
  assign MemWrite = MemW & commit;
  assign CondEx   = cond_ex;
  assign Flags    = flags_q;

  // Flag register. Reset wins over everything. The N,Z and C,V halves are
  // written independently, and an unwritten half holds its value.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for clocked state, so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      flags_q <= '0;
    end else if (commit) begin
      if (FlagW[1]) flags_q[3:2] <= ALUFlags[3:2];
      if (FlagW[0]) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

endmodule
